warp_xrf_wb_arb: RTL and testbench
==================================

// Module: warp_xrf_wb_arb
// PURPOSE
//  Writeback arbiter for the integer register file: shares the two xrf write ports (rd1/rd2)
//  among NREQ producers (xarith/xlogic lanes, load unit, multi-cycle units).
//  Round-robin grant of up to two writes per cycle, valid/ready per requester.
//  Never issues two same-cycle writes to one register. Write-port outputs are registered.
// PARAMETERS
//  NREQ   4   number of writeback requesters (2..8)
//  XLEN   64  data width
// PORTS
//  i_clk          in   1          clock; all state updates on posedge
//  i_rst_n        in   1          synchronous, active-low reset
//  i_stall        in   1          pipeline hold: no grants this cycle
//  i_req_valid    in   NREQ       requester i has a write pending
//  i_req_addr     in   NREQ*5     rd address, requester i at [5i+4:5i]
//  i_req_data     in   NREQ*XLEN  write data, requester i at [XLEN*i+XLEN-1:XLEN*i]
//  o_req_ready    out  NREQ       requester i granted; transfer when valid&ready
//  o_rd1_wen      out  1          xrf port 1 write enable
//  o_rd1_addr     out  5          xrf port 1 address
//  o_rd1_wdata    out  XLEN       xrf port 1 data
//  o_rd2_wen      out  1          xrf port 2 write enable
//  o_rd2_addr     out  5          xrf port 2 address
//  o_rd2_wdata    out  XLEN       xrf port 2 data
// BEHAVIOUR
//  - Reset (i_rst_n=0 at posedge): rd1/rd2 wen=0, addr=0, wdata=0; rr pointer=0. During reset, o_req_ready=0.
//  - o_req_ready is combinational from i_req_valid, i_req_addr, the rr pointer and i_stall.
//  - Requester rules: hold valid/addr/data stable until transfer; never drop valid without transfer.
//  - Grant A: the first valid index at or after ptr (wrapping mod NREQ) -> loaded into rd1 regs.
//  - Grant B: the next valid index after A (wrapping, stopping before ptr).
//    Its addr must differ from A's addr, or either addr must be 0. B is loaded into rd2 regs.
//    A valid whose addr equals A's nonzero addr is skipped this cycle, and the scan continues past it.
//  - Latency: 1 cycle. A grant at cycle n yields wen/addr/wdata at cycle n+1.
//    Outputs are held exactly one cycle; wen=0 otherwise.
//  - addr==0: transfer accepted (ready=1) but the corresponding wen=0; x0 is never written.
//  - Pointer: after >=1 grant, ptr = (last granted index + 1) mod NREQ. No grant -> ptr unchanged.
//  - i_stall=1: all ready=0, next-cycle wen=0, ptr unchanged; writes already registered still appear.
//  - Single valid requester: granted every cycle; throughput 1/cycle per requester, 2/cycle total.
//  - Reset mid-operation: a pending registered write is dropped (wen=0 next cycle);
//    requesters keep valid and are re-arbitrated from ptr=0.
// CONFIGURATION
//  WARP_XRF_WB_FWD_EN defined: adds outputs o_fwd_valid[1:0], o_fwd_addr[9:0] and o_fwd_data[2*XLEN-1:0].
//    These are a combinational copy of this cycle's grants A/B (valid excludes addr 0).
//    They let operand muxes bypass the registered xrf read.
//  Undefined: these ports and their logic are absent; port list otherwise identical.
// STRUCTURE
//  Shared package warp_pkg: XLEN, XRF_AW=5, and a localparam for the x0 address.
//    The fwd port widths are derived from these.
//  Sub-module warp_rr_pick: a rotating find-first-set over an NREQ mask, starting at a pointer,
//    returning index + found. Instantiate it twice: pick A, then pick B over the mask with A and
//    conflicting-address requesters removed.
// TESTING
//  1. Reset: hold i_rst_n=0 with all valid=1 -> ready=0, wen=0 both ports. Release -> req0->rd1, req1->rd2 next cycle.
//  2. Round robin: all 4 valid, distinct addrs 1..4, 3 cycles.
//     Grants are (0,1), (2,3), (0,1); wdata matches the source each time.
//  3. Conflict: req0 and req1 both addr 5, req2 addr 6, ptr=0 -> grants are 0 (rd1) and 2 (rd2).
//     req1 is granted next cycle on rd1.
//  4. x0: req0 addr 0, data 0xDEAD -> ready0=1, next-cycle rd1_wen=0.
//     With FWD_EN, o_fwd_valid[0]=0.
//  5. Stall: all valid, i_stall=1 for 2 cycles -> ready=0 and wen=0.
//     On release, grants resume from the unchanged ptr.
//  6. Backpressure: requester holds valid for 3 cycles while losing arbitration.
//     Assert data is stable and that it is written exactly once after its grant.

Source files
------------

// File: rtl/warp_pkg.sv
// Shared xrf constants for the warp integer writeback path.
package warp_pkg;
  localparam int XLEN   = 64;
  localparam int XRF_AW = 5;
  localparam logic [XRF_AW-1:0] XRF_X0 = '0;
  // Forwarding bus carries both grant slots side by side.
  localparam int FWD_AW = 2 * XRF_AW;

  // x0 is hardwired to zero, so writes to it are accepted but dropped.
  function automatic logic is_x0(input logic [XRF_AW-1:0] a);
    return a == XRF_X0;
  endfunction
endpackage

// File: rtl/warp_rr_pick.sv
// Rotating find-first-set: first set bit of i_mask at or after i_ptr, wrapping.
module warp_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);
  // Scan from farthest to nearest so the nearest set bit wins.
  always_comb begin
    int j;
    j       = 0;
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % N;
      if (i_mask[j]) begin
        o_found = 1'b1;
        o_idx   = IW'(j);
      end
    end
  end
endmodule

// File: rtl/warp_xrf_wb_arb.sv
// Writeback arbiter: round-robin shares xrf write ports rd1/rd2 among NREQ
// producers, never writing one register twice in a cycle.
// Optional feature macro: WARP_XRF_WB_FWD_EN (combinational grant forwarding).
module warp_xrf_wb_arb
  import warp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int XLEN = warp_pkg::XLEN
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_stall,
  input  logic [NREQ-1:0]          i_req_valid,
  input  logic [NREQ*XRF_AW-1:0]   i_req_addr,
  input  logic [NREQ*XLEN-1:0]     i_req_data,
  output logic [NREQ-1:0]          o_req_ready,
  output logic                     o_rd1_wen,
  output logic [XRF_AW-1:0]        o_rd1_addr,
  output logic [XLEN-1:0]          o_rd1_wdata,
  output logic                     o_rd2_wen,
  output logic [XRF_AW-1:0]        o_rd2_addr,
  output logic [XLEN-1:0]          o_rd2_wdata
`ifdef WARP_XRF_WB_FWD_EN
  ,
  output logic [1:0]               o_fwd_valid,
  output logic [FWD_AW-1:0]        o_fwd_addr,
  output logic [2*XLEN-1:0]        o_fwd_data
`endif
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0][XRF_AW-1:0] w_addr;
  logic [NREQ-1:0][XLEN-1:0]   w_data;
  logic [NREQ-1:0]             w_mask_a, w_mask_b, w_sel_a, w_sel_b, w_conf;
  logic [IW-1:0]               w_idx_a, w_idx_b, w_last;
  logic                        w_found_a, w_found_b, w_arb_en;
  logic [XRF_AW-1:0]           w_addr_a, w_addr_b;
  logic [XLEN-1:0]             w_data_a, w_data_b;
  logic                        w_a_nz, w_b_nz;

  logic [IW-1:0]               r_ptr;
  logic                        r_rd1_wen, r_rd2_wen;
  logic [XRF_AW-1:0]           r_rd1_addr, r_rd2_addr;
  logic [XLEN-1:0]             r_rd1_wdata, r_rd2_wdata;

  // Reset and stall both suppress every grant.
  assign w_arb_en = i_rst_n & ~i_stall;
  assign w_mask_a = i_req_valid & {NREQ{w_arb_en}};

  warp_rr_pick #(.N(NREQ), .IW(IW)) u_pick_a (
    .i_mask (w_mask_a),
    .i_ptr  (r_ptr),
    .o_idx  (w_idx_a),
    .o_found(w_found_a)
  );

  assign w_addr_a = w_addr[w_idx_a];
  assign w_data_a = w_data[w_idx_a];
  assign w_a_nz   = ~is_x0(w_addr_a);

  // Per-lane unpacking, A-select and same-register conflict detection.
  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign w_addr[g]  = i_req_addr[XRF_AW*g +: XRF_AW];
    assign w_data[g]  = i_req_data[XLEN*g +: XLEN];
    assign w_sel_a[g] = w_found_a && (w_idx_a == IW'(g));
    assign w_conf[g]  = w_a_nz && (w_addr[g] == w_addr_a);
    assign w_sel_b[g] = w_found_b && (w_idx_b == IW'(g));
  end

  // Nothing valid sits between ptr and A, so scanning B from ptr is the
  // same as scanning from A+1 up to (but not including) ptr.
  assign w_mask_b = w_mask_a & ~w_sel_a & ~w_conf;

  warp_rr_pick #(.N(NREQ), .IW(IW)) u_pick_b (
    .i_mask (w_mask_b),
    .i_ptr  (r_ptr),
    .o_idx  (w_idx_b),
    .o_found(w_found_b)
  );

  assign w_addr_b    = w_addr[w_idx_b];
  assign w_data_b    = w_data[w_idx_b];
  assign w_b_nz      = ~is_x0(w_addr_b);
  assign o_req_ready = w_sel_a | w_sel_b;
  assign w_last      = w_found_b ? w_idx_b : w_idx_a;

  // Pointer moves past the last granted index; held when nothing is granted.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_ptr <= '0;
    else if (w_found_a)
      r_ptr <= (w_last == IW'(NREQ - 1)) ? '0 : w_last + IW'(1);
  end

  // Registered write ports; wen lasts exactly one cycle per grant.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd1_wen   <= 1'b0;
      r_rd1_addr  <= '0;
      r_rd1_wdata <= '0;
      r_rd2_wen   <= 1'b0;
      r_rd2_addr  <= '0;
      r_rd2_wdata <= '0;
    end else begin
      r_rd1_wen <= w_found_a & w_a_nz;
      r_rd2_wen <= w_found_b & w_b_nz;
      if (w_found_a) begin
        r_rd1_addr  <= w_addr_a;
        r_rd1_wdata <= w_data_a;
      end
      if (w_found_b) begin
        r_rd2_addr  <= w_addr_b;
        r_rd2_wdata <= w_data_b;
      end
    end
  end

  assign o_rd1_wen   = r_rd1_wen;
  assign o_rd1_addr  = r_rd1_addr;
  assign o_rd1_wdata = r_rd1_wdata;
  assign o_rd2_wen   = r_rd2_wen;
  assign o_rd2_addr  = r_rd2_addr;
  assign o_rd2_wdata = r_rd2_wdata;

`ifdef WARP_XRF_WB_FWD_EN
  // Same-cycle copy of the grants for operand bypass; x0 never forwards.
  assign o_fwd_valid = {w_found_b & w_b_nz, w_found_a & w_a_nz};
  assign o_fwd_addr  = {w_addr_b, w_addr_a};
  assign o_fwd_data  = {w_data_b, w_data_a};
`endif
endmodule

// File: tb/tb_warp_xrf_wb_arb.sv
// Scoreboard bench for warp_xrf_wb_arb (NREQ=4, XLEN=64).
module tb_warp_xrf_wb_arb;
  localparam int NREQ = 4;
  localparam int XLEN = 64;
  localparam logic [63:0] TAG = 64'hBEEF_0000_0000_0006;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  logic                   clk, rst_n, stall;
  logic [NREQ-1:0]        v;
  logic [4:0]             a [NREQ];
  logic [63:0]            d [NREQ];
  logic [NREQ*5-1:0]      req_addr;
  logic [NREQ*XLEN-1:0]   req_data;
  logic [NREQ-1:0]        ready;
  logic                   rd1_wen, rd2_wen;
  logic [4:0]             rd1_addr, rd2_addr;
  logic [XLEN-1:0]        rd1_wdata, rd2_wdata;
`ifdef WARP_XRF_WB_FWD_EN
  logic [1:0]             fwd_valid;
  logic [9:0]             fwd_addr;
  logic [2*XLEN-1:0]      fwd_data;
`endif

  exp_t q1[$], q2[$];
  int   cyc = 0, checks = 0, errors = 0, tag_cnt = 0;
  bit   mon_en = 0;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[5*i +: 5]       = a[i];
      req_data[XLEN*i +: XLEN] = d[i];
    end
  end

  warp_xrf_wb_arb #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall),
    .i_req_valid(v), .i_req_addr(req_addr), .i_req_data(req_data),
    .o_req_ready(ready),
    .o_rd1_wen(rd1_wen), .o_rd1_addr(rd1_addr), .o_rd1_wdata(rd1_wdata),
    .o_rd2_wen(rd2_wen), .o_rd2_addr(rd2_addr), .o_rd2_wdata(rd2_wdata)
`ifdef WARP_XRF_WB_FWD_EN
    , .o_fwd_valid(fwd_valid), .o_fwd_addr(fwd_addr), .o_fwd_data(fwd_data)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare each write port every cycle against the scoreboard.
  task automatic mon_port(input int p, input logic wen, input logic [4:0] ad,
                          input logic [63:0] wd);
    exp_t e;
    bit   exp_now;
    if (p == 1) exp_now = (q1.size() > 0) && (q1[0].cyc == cyc);
    else        exp_now = (q2.size() > 0) && (q2[0].cyc == cyc);
    if (exp_now) begin
      if (p == 1) e = q1.pop_front();
      else        e = q2.pop_front();
    end
    checks++;
    if (wen !== exp_now) begin
      errors++;
      $display("FAIL rd%0d_wen cyc=%0d got=%b exp=%b", p, cyc, wen, exp_now);
    end else if (exp_now && (ad !== e.addr || wd !== e.data)) begin
      errors++;
      $display("FAIL rd%0d_write cyc=%0d got=%0d/%h exp=%0d/%h",
               p, cyc, ad, wd, e.addr, e.data);
    end
    if (wen === 1'b1 && wd === TAG) tag_cnt++;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_port(1, rd1_wen, rd1_addr, rd1_wdata);
      mon_port(2, rd2_wen, rd2_addr, rd2_wdata);
    end
  end

  task automatic set_data(input int tag);
    for (int i = 0; i < NREQ; i++) d[i] = {32'(tag), 32'(i)};
  endtask

  // One arbitration cycle: check ready, queue the hand-computed writes.
  task automatic step(input logic [3:0] exp_rdy, input int ga, input int gb);
    exp_t e;
    #1;
    checks++;
    if (ready !== exp_rdy) begin
      errors++;
      $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, exp_rdy);
    end
`ifdef WARP_XRF_WB_FWD_EN
    begin
      logic [1:0] efv;
      efv[0] = (ga >= 0) && (a[ga] != 5'd0);
      efv[1] = (gb >= 0) && (a[gb] != 5'd0);
      checks++;
      if (fwd_valid !== efv) begin
        errors++;
        $display("FAIL fwd_valid cyc=%0d got=%b exp=%b", cyc, fwd_valid, efv);
      end
    end
`endif
    if (ga >= 0 && a[ga] != 5'd0) begin
      e.cyc = cyc + 1; e.addr = a[ga]; e.data = d[ga]; q1.push_back(e);
    end
    if (gb >= 0 && a[gb] != 5'd0) begin
      e.cyc = cyc + 1; e.addr = a[gb]; e.data = d[gb]; q2.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; stall = 0; v = '0;
    for (int i = 0; i < NREQ; i++) begin a[i] = '0; d[i] = '0; end
    @(posedge clk); #1;
    mon_en = 1;

    // Reset held with all valid, then release; then round robin.
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3; a[3] = 5'd4;
    set_data(1); v = 4'b1111;
    step(4'b0000, -1, -1);
    step(4'b0000, -1, -1);
    rst_n = 1; set_data(2);
    step(4'b0011, 0, 1);
    set_data(3); step(4'b1100, 2, 3);
    set_data(4); step(4'b0011, 0, 1);
    v = 4'b0000; step(4'b0000, -1, -1);
    v = 4'b1000; a[3] = 5'd7; set_data(5);
    step(4'b1000, 3, -1);

    // Same-address conflict skipped for B, granted next cycle.
    a[0] = 5'd5; a[1] = 5'd5; a[2] = 5'd6; v = 4'b0111; set_data(6);
    step(4'b0101, 0, 2);
    v = 4'b0010;
    step(4'b0010, 1, -1);

    // x0 writes: accepted, never written; x0 pair may share a cycle.
    v = 4'b0001; a[0] = 5'd0; d[0] = 64'hDEAD;
    step(4'b0001, 0, -1);
    v = 4'b0011; a[1] = 5'd0;
    step(4'b0011, 1, 0);
    a[0] = 5'd9; a[1] = 5'd9; set_data(7);
    step(4'b0010, 1, -1);
    v = 4'b0001;
    step(4'b0001, 0, -1);

    // Stall for two cycles; resume from the unchanged pointer.
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3; a[3] = 5'd4;
    v = 4'b1111; set_data(8); stall = 1;
    step(4'b0000, -1, -1);
    step(4'b0000, -1, -1);
    stall = 0;
    step(4'b0110, 1, 2);

    // Requester 0 loses three cycles, holding its data, then wins once.
    a[0] = 5'd20; a[1] = 5'd11; a[2] = 5'd12; a[3] = 5'd20;
    set_data(9); d[0] = TAG; v = 4'b1111;
    step(4'b1010, 3, 1);
    a[2] = 5'd20; set_data(10); d[0] = TAG;
    step(4'b0110, 2, 1);
    set_data(11); d[0] = TAG;
    step(4'b0110, 2, 1);
    v = 4'b0001;
    step(4'b0001, 0, -1);

    // Mid-run reset returns the pointer to 0.
    a[0] = 5'd13; a[3] = 5'd14; set_data(12); v = 4'b1001; rst_n = 0;
    step(4'b0000, -1, -1);
    rst_n = 1;
    step(4'b1001, 0, 3);
    v = 4'b0000;
    step(4'b0000, -1, -1);
    step(4'b0000, -1, -1);

    checks++;
    if (tag_cnt != 1) begin
      errors++;
      $display("FAIL once_write got=%0d exp=1", tag_cnt);
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d exp=0/0", q1.size(), q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
